// File: rtl/key_region_scanner_pkg.sv
// Shared types and helpers for the key region scanner: RGB333 pixel layout,
// the dark-pixel luma sum and the scanner state encoding.
package key_region_scanner_pkg;

  typedef logic [8:0] rgb333_t;

  localparam int unsigned R_LSB = 6;
  localparam int unsigned G_LSB = 3;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    WAIT_SOF,
    SCAN,
    EMIT
  } scan_state_e;

  // r+g+b of an RGB333 pixel, 0..21
  function automatic logic [4:0] luma_sum(rgb333_t p);
    return 5'(p[R_LSB +: 3]) + 5'(p[G_LSB +: 3]) + 5'(p[B_LSB +: 3]);
  endfunction

endpackage

// File: rtl/key_region_scanner_if.sv
// Pixel stream in / key result out bundle of the key region scanner.
interface key_region_scanner_if #(
  parameter int unsigned NUM_KEYS = 8
);
  import key_region_scanner_pkg::*;

  logic                pix_valid;
  logic                pix_sof;
  rgb333_t             pix_data;
  logic [NUM_KEYS-1:0] key_mask;
  logic                key_valid;
  logic                key_change;
  logic [15:0]         frame_cnt;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  key_mask, key_valid, key_change, frame_cnt
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output key_mask, key_valid, key_change, frame_cnt
  );

endinterface

// File: rtl/key_region_scanner_debounce.sv
// Per-key frame debouncer, only built with KEY_DEBOUNCE_EN defined.
// flip_o requests the key to take the raw value after DEB_FRAMES
// consecutive completed frames disagreeing with the current key state.
`ifdef KEY_DEBOUNCE_EN
module key_debounce #(
  parameter int unsigned DEB_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic upd_i,
  input  logic raw_i,
  input  logic cur_i,
  output logic flip_o
);

  localparam int unsigned CNT_W = $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // disagreement counter: cleared by an agreeing frame or by a flip
  always_comb begin
    cnt_d  = cnt_q;
    flip_o = 1'b0;
    if (upd_i) begin
      if (raw_i == cur_i) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        flip_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/key_region_scanner.sv
// Key region scanner: counts dark pixels per vertical key band inside a
// row window once per frame and reports the pressed-key mask.
// Optional feature macro: KEY_DEBOUNCE_EN (per-key frame debounce).
module key_region_scanner
  import key_region_scanner_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned NUM_KEYS    = 8,
  parameter int unsigned ROW_TOP     = 400,
  parameter int unsigned ROW_BOT     = 463,
  parameter int unsigned DARK_THRESH = 6,
  parameter int unsigned HIT_COUNT   = 1024,
  parameter int unsigned DEB_FRAMES  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  key_region_scanner_if.slave  bus
);

  localparam int unsigned BAND_W   = H_RES / NUM_KEYS;
  localparam int unsigned WIN_ROWS = ROW_BOT - ROW_TOP + 1;
  localparam int unsigned X_W      = (H_RES > 1)    ? $clog2(H_RES)    : 1;
  localparam int unsigned Y_W      = (V_RES > 1)    ? $clog2(V_RES)    : 1;
  localparam int unsigned BX_W     = (BAND_W > 1)   ? $clog2(BAND_W)   : 1;
  localparam int unsigned BI_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned ACC_W    = $clog2(BAND_W * WIN_ROWS + 1);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_RES - 1);
  localparam logic [BX_W-1:0]  BX_LAST = BX_W'(BAND_W - 1);
  localparam logic [Y_W-1:0]   Y_TOP   = Y_W'(ROW_TOP);
  localparam logic [Y_W-1:0]   Y_BOT   = Y_W'(ROW_BOT);
  localparam logic [4:0]       THR     = 5'(DARK_THRESH);
  localparam logic [ACC_W:0]   HIT_V   = (ACC_W + 1)'(HIT_COUNT);

  if (BAND_W * NUM_KEYS != H_RES || DEB_FRAMES < 1) begin : g_bad_cfg
    $error("key_region_scanner: H_RES must split evenly into NUM_KEYS bands");
  end

  scan_state_e state_q, state_d;
  logic [X_W-1:0]  x_q, x_d, cur_x;
  logic [Y_W-1:0]  y_q, y_d, cur_y;
  logic [BX_W-1:0] bx_q, bx_d, cur_bx;
  logic [BI_W-1:0] bi_q, bi_d, cur_bi;
  logic            take, cur_last, cur_win;

  logic            p0_vld_q, p0_first_q, p0_win_q, p0_last_q;
  rgb333_t         p0_pix_q;
  logic [BI_W-1:0] p0_bi_q;
  logic            s1_vld_q, s1_first_q, s1_dark_q, s1_win_q, s1_last_q;
  logic [BI_W-1:0] s1_bi_q;
  logic            done_q;

  logic [ACC_W-1:0]    acc_q [NUM_KEYS];
  logic [ACC_W-1:0]    acc_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] raw, new_mask;
  logic [NUM_KEYS-1:0] key_mask_q;
  logic                key_valid_q, key_change_q;
  logic [15:0]         frame_cnt_q;

  // Position tracking and frame FSM; a sof pixel always restarts at (0,0),
  // which also covers the short-frame restart and sof during EMIT.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    bx_d     = bx_q;
    bi_d     = bi_q;
    cur_x    = bus.pix_sof ? '0 : x_q;
    cur_y    = bus.pix_sof ? '0 : y_q;
    cur_bx   = bus.pix_sof ? '0 : bx_q;
    cur_bi   = bus.pix_sof ? '0 : bi_q;
    cur_last = (cur_x == X_LAST) && (cur_y == Y_LAST);
    cur_win  = (cur_y >= Y_TOP) && (cur_y <= Y_BOT);
    take     = bus.pix_valid && (bus.pix_sof || state_q == SCAN);
    if (take) begin
      if (cur_x == X_LAST) begin
        x_d  = '0;
        y_d  = cur_last ? '0 : cur_y + 1'b1;
        bx_d = '0;
        bi_d = '0;
      end else begin
        x_d = cur_x + 1'b1;
        y_d = cur_y;
        if (cur_bx == BX_LAST) begin
          bx_d = '0;
          bi_d = cur_bi + 1'b1;
        end else begin
          bx_d = cur_bx + 1'b1;
          bi_d = cur_bi;
        end
      end
      state_d = cur_last ? EMIT : SCAN;
    end else if (state_q == EMIT && done_q) begin
      state_d = WAIT_SOF;
    end
  end

  // FSM and position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      bx_q    <= '0;
      bi_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bx_q    <= bx_d;
      bi_q    <= bi_d;
    end
  end

  // Input capture, S1 classification and end-of-frame marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_vld_q   <= 1'b0;
      p0_first_q <= 1'b0;
      p0_pix_q   <= '0;
      p0_bi_q    <= '0;
      p0_win_q   <= 1'b0;
      p0_last_q  <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_dark_q  <= 1'b0;
      s1_bi_q    <= '0;
      s1_win_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      p0_vld_q   <= take;
      p0_first_q <= take && bus.pix_sof;
      p0_pix_q   <= bus.pix_data;
      p0_bi_q    <= cur_bi;
      p0_win_q   <= cur_win;
      p0_last_q  <= cur_last;
      s1_vld_q   <= p0_vld_q;
      s1_first_q <= p0_first_q;
      s1_dark_q  <= (luma_sum(p0_pix_q) <= THR);
      s1_bi_q    <= p0_bi_q;
      s1_win_q   <= p0_win_q;
      s1_last_q  <= p0_last_q;
      done_q     <= s1_vld_q && s1_last_q;
    end
  end

  // Saturating band accumulators. They are zeroed when a frame's first pixel
  // reaches this stage rather than on abort or emit: that discards any partial
  // frame ahead of it, and since the first pixel of a back-to-back frame
  // arrives no earlier than the compare edge (which reads acc_q), clearing
  // and comparing can never alias.
  always_comb begin
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      acc_d[k] = (s1_vld_q && s1_first_q) ? '0 : acc_q[k];
      if (s1_vld_q && s1_dark_q && s1_win_q && (s1_bi_q == BI_W'(k)) && (acc_d[k] != '1))
        acc_d[k] = acc_d[k] + 1'b1;
      raw[k] = ({1'b0, acc_q[k]} >= HIT_V);
    end
  end

  // accumulator registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '{default: '0};
    else      acc_q <= acc_d;
  end

`ifdef KEY_DEBOUNCE_EN
  logic [NUM_KEYS-1:0] flip;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    key_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
      .clk    (clk),
      .rst_n  (rst),
      .upd_i  (done_q),
      .raw_i  (raw[k]),
      .cur_i  (key_mask_q[k]),
      .flip_o (flip[k])
    );
  end

  assign new_mask = (flip & raw) | (~flip & key_mask_q);
`else
  assign new_mask = raw;
`endif

  // Result registers, updated on the compare edge of each completed frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_mask_q   <= '0;
      key_valid_q  <= 1'b0;
      key_change_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      key_valid_q  <= done_q;
      key_change_q <= done_q && (new_mask != key_mask_q);
      if (done_q) begin
        key_mask_q  <= new_mask;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign bus.key_mask   = key_mask_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.key_change = key_change_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_key_region_scanner.sv
// Directed self-checking bench for key_region_scanner on a reduced frame
// (32x12, 8 bands of 4 pixels, window rows 8..9, 5 dark pixels press a key).
// Build with KEY_DEBOUNCE_EN to exercise the debounced variant.
module tb_key_region_scanner;
  import key_region_scanner_pkg::*;

  localparam int H   = 32;
  localparam int V   = 12;
  localparam int NK  = 8;
  localparam int RT  = 8;
  localparam int RB  = 9;
  localparam int HIT = 5;
`ifdef KEY_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif

  localparam rgb333_t WHITE = 9'h1FF;
  localparam rgb333_t DARK6 = 9'b010_010_010;
  localparam rgb333_t GREY7 = 9'b011_010_010;
  localparam rgb333_t BLACK = 9'h000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_region_scanner_if #(.NUM_KEYS(NK)) bus ();

  key_region_scanner #(
    .H_RES(H), .V_RES(V), .NUM_KEYS(NK), .ROW_TOP(RT), .ROW_BOT(RB),
    .DARK_THRESH(6), .HIT_COUNT(HIT), .DEB_FRAMES(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  rgb333_t bg, dk_color;
  int      dk_band, dk_n;
  bit      edge_rows;

  logic [8:0] kv_q[$];

  // record every key_valid pulse as {key_change, key_mask}
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) kv_q.push_back({bus.key_change, bus.key_mask});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic rgb333_t pix_at(int x, int y);
    bit dk;
    if (edge_rows) dk = (y == RT - 1) || (y == RB + 1);
    else           dk = (x / 4 == dk_band) && (y >= RT) && (y <= RB) &&
                        (((y - RT) * 4 + x % 4) < dk_n);
    return dk ? dk_color : bg;
  endfunction

  task automatic set_pat(rgb333_t b, rgb333_t c, int band, int n, bit er);
    bg = b; dk_color = c; dk_band = band; dk_n = n; edge_rows = er;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixel(bit sof, rgb333_t d);
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  // stop_line >= 0 ends the frame before that line is sent
  task automatic send_frame(int stop_line, bit gaps);
    for (int y = 0; y < V; y++) begin
      if (y == stop_line) return;
      for (int x = 0; x < H; x++) begin
        if (gaps && $urandom_range(0, 1) == 1) idle(1);
        send_pixel(x == 0 && y == 0, pix_at(x, y));
      end
    end
  endtask

  task automatic run_frame(string tag, bit gaps, logic [7:0] exp_mask, bit exp_change);
    int n;
    send_frame(-1, gaps);
    exp_cnt++;
    n = 0;
    while (n < 8 && bus.key_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, 3);
    check({tag, " key_mask"}, bus.key_mask, exp_mask);
    check({tag, " key_change"}, bus.key_change, exp_change);
    check({tag, " frame_cnt"}, bus.frame_cnt, exp_cnt);
    idle(1);
    check({tag, " pulse width"}, {bus.key_valid, bus.key_change}, 0);
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;
    set_pat(WHITE, DARK6, -1, 0, 1'b0);

    idle(3);
    check("reset key_mask", bus.key_mask, 0);
    check("reset key_valid", bus.key_valid, 0);
    check("reset key_change", bus.key_change, 0);
    check("reset frame_cnt", bus.frame_cnt, 0);
    rst = 1'b1;
    idle(2);

    repeat (3) send_pixel(1'b0, BLACK);
    idle(6);
    check("stray pixels ignored", kv_q.size(), 0);

`ifndef KEY_DEBOUNCE_EN
    set_pat(WHITE, DARK6, -1, 0, 1'b0);
    run_frame("white", 1'b0, 8'h00, 1'b0);
    set_pat(WHITE, DARK6, 2, 8, 1'b0);
    run_frame("band2", 1'b0, 8'h04, 1'b1);
    run_frame("band2 repeat", 1'b0, 8'h04, 1'b0);
    set_pat(WHITE, DARK6, 5, HIT - 1, 1'b0);
    run_frame("band5 hit-1", 1'b0, 8'h00, 1'b1);
    set_pat(WHITE, DARK6, 5, HIT, 1'b0);
    run_frame("band5 hit", 1'b0, 8'h20, 1'b1);
    set_pat(WHITE, DARK6, -1, 0, 1'b1);
    run_frame("outside window", 1'b0, 8'h00, 1'b1);
    set_pat(WHITE, GREY7, 3, 8, 1'b0);
    run_frame("sum 7 not dark", 1'b0, 8'h00, 1'b0);

    // black frame cut short after the window rows, then a full white frame
    kv_q.delete();
    set_pat(BLACK, DARK6, -1, 0, 1'b0);
    send_frame(10, 1'b0);
    set_pat(WHITE, DARK6, -1, 0, 1'b0);
    run_frame("after abort", 1'b0, 8'h00, 1'b0);
    check("abort pulse count", kv_q.size(), 1);

    // second frame's sof follows the last pixel with no idle cycle
    kv_q.delete();
    set_pat(WHITE, DARK6, 2, 8, 1'b0);
    send_frame(-1, 1'b0);
    set_pat(WHITE, DARK6, 0, 8, 1'b0);
    send_frame(-1, 1'b0);
    exp_cnt += 2;
    idle(6);
    check("b2b pulse count", kv_q.size(), 2);
    check("b2b first result", kv_q[0], 9'h104);
    check("b2b second result", kv_q[1], 9'h101);
    check("b2b frame_cnt", bus.frame_cnt, exp_cnt);

    set_pat(WHITE, DARK6, 6, 8, 1'b0);
    run_frame("gaps band6", 1'b1, 8'h40, 1'b1);
`else
    set_pat(WHITE, DARK6, 0, 8, 1'b0);
    run_frame("deb dark1", 1'b0, 8'h00, 1'b0);
    run_frame("deb dark2", 1'b0, 8'h00, 1'b0);
    set_pat(WHITE, DARK6, -1, 0, 1'b0);
    run_frame("deb white", 1'b0, 8'h00, 1'b0);
    set_pat(WHITE, DARK6, 0, 8, 1'b0);
    run_frame("deb dark1b", 1'b0, 8'h00, 1'b0);
    run_frame("deb dark2b", 1'b0, 8'h00, 1'b0);
    run_frame("deb dark3b", 1'b0, 8'h01, 1'b1);
    set_pat(WHITE, DARK6, -1, 0, 1'b0);
    run_frame("deb white1", 1'b1, 8'h01, 1'b0);
    run_frame("deb white2", 1'b0, 8'h01, 1'b0);
    run_frame("deb white3", 1'b0, 8'h00, 1'b1);
    set_pat(WHITE, DARK6, 3, 8, 1'b0);
    run_frame("deb dark1c", 1'b0, 8'h00, 1'b0);
    run_frame("deb dark2c", 1'b0, 8'h00, 1'b0);
    run_frame("deb dark3c", 1'b0, 8'h08, 1'b1);
`endif

    // asynchronous reset while window pixels are still in the pipeline
    set_pat(WHITE, DARK6, 1, 8, 1'b0);
    send_frame(10, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("midframe rst key_mask", bus.key_mask, 0);
    check("midframe rst key_valid", bus.key_valid, 0);
    check("midframe rst key_change", bus.key_change, 0);
    check("midframe rst frame_cnt", bus.frame_cnt, 0);
    idle(2);
    rst = 1'b1;
    exp_cnt = 0;
    idle(1);
    repeat (3) send_pixel(1'b0, BLACK);
    run_frame("post reset band1", 1'b0, DEB ? 8'h00 : 8'h02, !DEB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
